// File: rtl/wall_depth_controller.sv
// wall_depth_controller: paces a wall toward the player one unit per FRAMES_PER_STEP frames, then judges the player's depth.
// Ports: clk_in clock; rst_in sync active-low reset; start_in begins a round; new_frame_in frame pulse;
//   player_depth_in raw depth; wall_depth_out / player_depth_out sprite depths; busy_out round active;
//   result_valid_out verdict pulse; pass_out last verdict.
// Build option: define WALL_DEPTH_SMOOTH_EN to average the last 4 frame samples of player depth.
module wall_depth_controller #(
  parameter int unsigned GOAL_DEPTH       = 60,
  parameter int unsigned GOAL_DEPTH_DELTA = 10,
  parameter int unsigned MAX_WALL_DEPTH   = 75,
  parameter int unsigned FRAMES_PER_STEP  = 4
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       start_in,
  input  logic       new_frame_in,
  input  logic [7:0] player_depth_in,
  output logic [7:0] wall_depth_out,
  output logic [7:0] player_depth_out,
  output logic       busy_out,
  output logic       result_valid_out,
  output logic       pass_out
);
  typedef enum logic [1:0] {IDLE, MOVING, JUDGE, DONE} state_t;
  localparam logic [8:0] GOAL9  = 9'(GOAL_DEPTH);
  localparam logic [8:0] DELTA9 = 9'(GOAL_DEPTH_DELTA);
  localparam logic [8:0] HI9    = 9'(GOAL_DEPTH + GOAL_DEPTH_DELTA);
  localparam logic [7:0] MAX8   = 8'(MAX_WALL_DEPTH);
  localparam logic [7:0] LAST8  = 8'(FRAMES_PER_STEP - 1);
  state_t     state_q, state_d;
  logic [7:0] wall_q, wall_d, cnt_q, cnt_d, player_q, player_d;
  logic       pass_q, pass_d, valid_q, valid_d, busy_q, busy_d;
  logic       in_window;
  // Lower bound is tested as player+delta >= goal so a goal below delta never wraps.
  assign in_window = ({1'b0, player_q} + DELTA9 >= GOAL9) && ({1'b0, player_q} <= HI9);
  always_comb begin
    state_d = state_q;
    wall_d  = wall_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    case (state_q)
      IDLE: if (start_in) begin
        state_d = MOVING;
        wall_d  = '0;
        cnt_d   = '0;
        pass_d  = 1'b0;
      end
      MOVING: if (wall_q >= MAX8) state_d = JUDGE;
        else if (new_frame_in) begin
          cnt_d  = (cnt_q == LAST8) ? 8'd0 : cnt_q + 8'd1;
          wall_d = (cnt_q == LAST8) ? wall_q + 8'd1 : wall_q;
        end
      JUDGE: begin
        pass_d  = in_window;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
    valid_d = (state_d == DONE);
    busy_d  = (state_d != IDLE);
  end
`ifdef WALL_DEPTH_SMOOTH_EN
  logic [2:0][7:0] hist_q, hist_d;
  logic [9:0]      sum;
  always_comb begin
    sum      = 10'(player_depth_in) + 10'(hist_q[0]) + 10'(hist_q[1]) + 10'(hist_q[2]);
    hist_d   = new_frame_in ? {hist_q[1:0], player_depth_in} : hist_q;
    player_d = new_frame_in ? sum[9:2] : player_q;
  end
  always_ff @(posedge clk_in) hist_q <= !rst_in ? '0 : hist_d;
`else
  always_comb player_d = new_frame_in ? player_depth_in : player_q;
`endif
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q  <= IDLE;
      wall_q   <= '0;
      cnt_q    <= '0;
      player_q <= '0;
      pass_q   <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wall_q   <= wall_d;
      cnt_q    <= cnt_d;
      player_q <= player_d;
      pass_q   <= pass_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end
  assign wall_depth_out   = wall_q;
  assign player_depth_out = player_q;
  assign busy_out         = busy_q;
  assign result_valid_out = valid_q;
  assign pass_out         = pass_q;
endmodule

// File: tb/tb_wall_depth_controller.sv
// tb_wall_depth_controller: randomized rounds checked against a frame-counting reference model.
module tb_wall_depth_controller;
  localparam int FPS = 2, MAXW = 75, GOAL = 60, DELTA = 10;
  logic       clk_in = 0, rst_in = 0, start_in = 0, new_frame_in = 0;
  logic [7:0] player_depth_in = 0;
  logic [7:0] wall_depth_out, player_depth_out;
  logic       busy_out, result_valid_out, pass_out;
  wall_depth_controller #(.GOAL_DEPTH(GOAL), .GOAL_DEPTH_DELTA(DELTA), .MAX_WALL_DEPTH(MAXW),
                          .FRAMES_PER_STEP(FPS)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .new_frame_in(new_frame_in),
    .player_depth_in(player_depth_in), .wall_depth_out(wall_depth_out),
    .player_depth_out(player_depth_out), .busy_out(busy_out),
    .result_valid_out(result_valid_out), .pass_out(pass_out));
  always #5 clk_in = ~clk_in;
  int n_cmp = 0, n_bad = 0;
  bit m_active = 0, m_pass = 0;
  int m_nfr = 0, m_t = -1, m_player = 0;
  int m_hist[4] = '{default: 0};
  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  function automatic int exp_wall();
    return (m_nfr / FPS < MAXW) ? m_nfr / FPS : MAXW;
  endfunction
  function automatic bit in_win(input int p);
    return p >= GOAL - DELTA && p <= GOAL + DELTA;
  endfunction
  task automatic model_edge(input bit s, input bit nf, input int pd, input bit r);
    if (!r) begin
      m_active = 0; m_pass = 0; m_nfr = 0; m_t = -1; m_player = 0;
      m_hist = '{default: 0};
      return;
    end
    if (!m_active) begin
      if (s) begin m_active = 1; m_nfr = 0; m_t = -1; m_pass = 0; end
    end else if (m_t < 0) begin
      if (nf) m_nfr++;
      if (m_nfr / FPS >= MAXW) m_t = 0;
    end else begin
      m_t++;
      if (m_t == 2) m_pass = in_win(m_player);
      if (m_t == 3) begin m_active = 0; m_t = -1; end
    end
    if (nf) begin
      m_hist = '{pd, m_hist[0], m_hist[1], m_hist[2]};
`ifdef WALL_DEPTH_SMOOTH_EN
      m_player = (m_hist[0] + m_hist[1] + m_hist[2] + m_hist[3]) / 4;
`else
      m_player = pd;
`endif
    end
  endtask
  task automatic step(input bit s, input bit nf, input int pd, input bit r);
    @(negedge clk_in);
    start_in = s; new_frame_in = nf; player_depth_in = 8'(pd); rst_in = r;
    @(posedge clk_in);
    model_edge(s, nf, pd, r);
    #1;
    check("wall", wall_depth_out, exp_wall());
    check("player", player_depth_out, m_player);
    check("busy", busy_out, m_active);
    check("valid", result_valid_out, m_active && m_t == 2);
    check("pass", pass_out, m_pass);
  endtask
  task automatic round(input int depth, input int rst_at, input int start_at);
    bit r;
    step(1, 1, depth, 1);
    for (int i = 0; i < 3000 && m_active; i++) begin
      r = !(rst_at >= 0 && m_t < 0 && exp_wall() == rst_at);
      step((start_at >= 0 && exp_wall() == start_at) || ($urandom % 16 == 0),
           1'($urandom % 2), depth, r);
    end
    if (m_active) check("round_timeout", 1, 0);
  endtask
  int depths[5] = '{60, 71, 70, 50, 49};
  bit exp_p[5]  = '{1, 0, 1, 1, 0};
  int d;
  initial begin
    step(0, 1, 99, 0);
    step(0, 0, 0, 0);
    check("rst_wall", wall_depth_out, 0);
    check("rst_busy", busy_out, 0);
    step(0, 0, 0, 1);
    step(0, 1, 40, 1);
    step(0, 1, 40, 1);
    step(0, 1, 80, 1);
    step(0, 1, 80, 1);
`ifdef WALL_DEPTH_SMOOTH_EN
    check("smooth_mean", player_depth_out, 60);
`else
    check("last_sample", player_depth_out, 80);
`endif
    for (int k = 0; k < 5; k++) begin
      round(depths[k], -1, 10);
      check($sformatf("pass_d%0d", depths[k]), pass_out, exp_p[k]);
      check("wall_hold", wall_depth_out, MAXW);
      repeat (3) step(0, 1'($urandom % 2), $urandom_range(0, 255), 1);
      check("pass_hold", pass_out, exp_p[k]);
    end
    round(55, 30, -1);
    check("midrst_wall", wall_depth_out, 0);
    check("midrst_busy", busy_out, 0);
    check("midrst_pass", pass_out, 0);
    round(55, -1, -1);
    check("restart_pass", pass_out, 1);
    for (int k = 0; k < 3; k++) begin
      d = $urandom_range(30, 90);
      round(d, -1, -1);
      check($sformatf("rand_pass_d%0d", d), pass_out, int'(in_win(d)));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/wall_depth_controller.md
WALL_DEPTH_CONTROLLER -- requirements
Module: wall_depth_controller

Interface
REQ-001 SHALL have parameter GOAL_DEPTH, default 60: centre of the passing player depth window.
REQ-002 SHALL have parameter GOAL_DEPTH_DELTA, default 10: half-width of the passing window, inclusive.
REQ-003 SHALL have parameter MAX_WALL_DEPTH, default 75: wall depth at which the round is judged.
REQ-004 SHALL have parameter FRAMES_PER_STEP, default 4: frames per one-unit wall advance, range 1..255.
REQ-005 SHALL have port clk_in, input, 1: the single clock; all logic runs on its rising edge.
REQ-006 SHALL have port rst_in, input, 1: reset, synchronous and active-low.
REQ-007 SHALL have port start_in, input, 1: single-cycle pulse that begins a round.
REQ-008 SHALL have port new_frame_in, input, 1: single-cycle pulse, once per video frame.
REQ-009 SHALL have port player_depth_in, input, 8: raw player depth from the depth pipeline.
REQ-010 SHALL have port wall_depth_out, output, 8: current wall depth, drives the depth sprite.
REQ-011 SHALL have port player_depth_out, output, 8: frame-stable player depth, drives the depth sprite.
REQ-012 SHALL have port busy_out, output, 1: high in any state other than IDLE.
REQ-013 SHALL have port result_valid_out, output, 1: single-cycle pulse when a verdict is issued.
REQ-014 SHALL have port pass_out, output, 1: verdict of the last completed round.

Function
REQ-015 SHALL implement states IDLE, MOVING, JUDGE and DONE; reset state is IDLE.
REQ-016 IDLE: start_in=1 SHALL go to MOVING next cycle and clear wall_depth_out, the frame counter and pass_out; a new_frame_in in the same cycle SHALL NOT be counted.
REQ-017 MOVING: each new_frame_in SHALL increment the frame counter; when the count reaches FRAMES_PER_STEP-1, the counter SHALL go to 0 and wall_depth_out SHALL increment by 1 on the same edge.
REQ-018 When wall_depth_out becomes MAX_WALL_DEPTH, MOVING SHALL go to JUDGE on the next cycle; wall_depth_out SHALL never exceed MAX_WALL_DEPTH.
REQ-019 JUDGE (1 cycle): pass_out SHALL load 1 iff GOAL_DEPTH-GOAL_DEPTH_DELTA <= player_depth_out <= GOAL_DEPTH+GOAL_DEPTH_DELTA, as an unsigned compare with 9-bit intermediates and no wrap; the state SHALL then go to DONE.
REQ-020 DONE (1 cycle): result_valid_out SHALL be 1, then the state SHALL go to IDLE; pass_out and wall_depth_out SHALL hold until the next start.
REQ-021 start_in SHALL be ignored in MOVING, JUDGE and DONE.
REQ-022 player_depth_out SHALL update only on the edge following a new_frame_in, in any state, so its value is constant within a frame.
REQ-023 Verdict latency: result_valid_out SHALL assert exactly 2 cycles after wall_depth_out first equals MAX_WALL_DEPTH.

Reset
REQ-024 rst_in=0 at a clock edge SHALL force IDLE, wall_depth_out=0, player_depth_out=0, frame counter 0, busy_out=0, result_valid_out=0 and pass_out=0, including mid-round.
REQ-025 rst_in SHALL take priority over start_in and new_frame_in in the same cycle.

Configuration
REQ-026 Macro WALL_DEPTH_SMOOTH_EN defined: player_depth_out SHALL be the mean of the last 4 frame samples (10-bit sum, shifted right by 2); the sample history SHALL reset to 0.
REQ-027 Macro WALL_DEPTH_SMOOTH_EN undefined: player_depth_out SHALL equal player_depth_in as sampled at the last new_frame_in.

Verification
REQ-028 FRAMES_PER_STEP=2, MAX_WALL_DEPTH=75, start, then 150 frames with player_depth_in=60 -> wall_depth_out reaches 75 after frame 150, result_valid_out pulses 2 cycles later, pass_out=1.
REQ-029 Same setup with player_depth_in=71 -> pass_out=0; with 70 -> pass_out=1; with 50 -> pass_out=1; with 49 -> pass_out=0.
REQ-030 rst_in=0 for 1 cycle when wall_depth_out=30 -> next cycle all outputs are 0 and state is IDLE; a later start_in restarts the round from wall_depth_out=0.
REQ-031 start_in pulse during MOVING at wall_depth_out=10 -> no change; start_in coincident with new_frame_in in IDLE -> frame counter stays 0.
REQ-032 With WALL_DEPTH_SMOOTH_EN, samples 40,40,80,80 -> player_depth_out=60; without the macro -> player_depth_out=80.
